fxpsm_matmul_array: RTL and testbench

FXPSM_MATMUL_ARRAY -- requirements
Module: fxpsm_matmul_array

---
 rtl/fxpsm_pkg.sv | 20 ++
 rtl/fxpsm_mac_pe.sv | 50 +++++
 rtl/fxpsm_matmul_array.sv | 160 ++++++++++++++++
 tb/tb_fxpsm_matmul_array.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxpsm_pkg.sv
// rtl/fxpsm_pkg.sv - shared state encoding and width/saturation helpers for the matmul array
package fxpsm_pkg;

   typedef enum logic [1:0] {
      ST_LOAD    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   // Accumulator width: exact product (2W) plus headroom for N terms
   function automatic int acc_width(input int n, input int w);
      return 2 * w + $clog2(n);
   endfunction

   // Largest representable sign-magnitude magnitude
   function automatic int sat_mag(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fxpsm_mac_pe.sv
// rtl/fxpsm_mac_pe.sv - sign-magnitude multiply-accumulate cell with finalise to element format
module fxpsm_mac_pe
   import fxpsm_pkg::*;
#(
   parameter int N    = 3,
   parameter int W    = 8,
   parameter int FRAC = 3
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res
);

   localparam int AW = acc_width(N, W);
   localparam int PW = 2 * W - 2;
   localparam logic [W-2:0] SAT_M = (W-1)'(sat_mag(W));

   logic [PW-1:0] prod_mag;
   logic          prod_sign;
   logic [AW-1:0] prod_ext;
   logic [AW-1:0] acc;
   logic [AW-1:0] mag;
   logic [AW-1:0] shf;
   logic [W-2:0]  rmag;

   assign prod_mag  = PW'(a[W-2:0]) * PW'(b[W-2:0]);
   assign prod_sign = a[W-1] ^ b[W-1];
   assign prod_ext  = AW'(prod_mag);

   // Two's complement accumulation of the exact signed product
   always_ff @(posedge clk) begin
      if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= prod_sign ? acc - prod_ext : acc + prod_ext;
      end
   end

   // Finalise: magnitude, truncating shift, saturate, and force zero to +0
   always_comb begin
      mag  = acc[AW-1] ? (~acc + AW'(1)) : acc;
      shf  = mag >> FRAC;
      rmag = (shf > AW'(SAT_M)) ? SAT_M : shf[W-2:0];
      res  = (rmag == '0) ? '0 : {acc[AW-1], rmag};
   end

endmodule

// File: rtl/fxpsm_matmul_array.sv
// rtl/fxpsm_matmul_array.sv - NxN sign-magnitude fixed-point matrix multiplier with load/compute/output
module fxpsm_matmul_array
   import fxpsm_pkg::*;
#(
   parameter int N    = 3,
   parameter int W    = 8,
   parameter int FRAC = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mat,
   input  logic         in_new_row,
   input  logic         in_mat_done,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_new_row,
   output logic         out_last,
   output logic [W-1:0] out_data
);

   localparam int PW = $clog2(N);
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   state_t        state;
   logic [1:0]    ld;
   logic [1:0]    pad_all;
   logic [1:0]    beat_acc;
   logic [1:0]    pad_row;
   logic [1:0]    wr;
   logic [1:0]    last_pos;
   logic [1:0]    ld_next;
   logic [PW-1:0] row_ptr [2];
   logic [PW-1:0] col_ptr [2];
   logic [PW-1:0] k_ptr;
   logic [PW-1:0] orow;
   logic [PW-1:0] ocol;
   logic [W-1:0]  mem [2][N][N];
   logic [W-1:0]  res [N][N];
   logic          pe_clr;
   logic          pe_en;

   // A beat is refused while its matrix is full, tail-padding, or row-padding ahead of it
   assign in_ready = rstn && (state == ST_LOAD) && !ld[in_mat] && !pad_all[in_mat]
                     && !(in_new_row && (col_ptr[in_mat] != '0));

   // Per-matrix write decision: accepted beat, row pad, or tail pad
   always_comb begin
      beat_acc = '0;
      pad_row  = '0;
      wr       = '0;
      last_pos = '0;
      ld_next  = '0;
      for (int m = 0; m < 2; m++) begin
         beat_acc[m] = in_valid && in_ready && (in_mat == 1'(m));
         pad_row[m]  = (state == ST_LOAD) && in_valid && (in_mat == 1'(m)) && in_new_row
                       && (col_ptr[m] != '0) && !ld[m] && !pad_all[m];
         wr[m]       = beat_acc[m] || pad_row[m] || (pad_all[m] && (state == ST_LOAD));
         last_pos[m] = (row_ptr[m] == LAST) && (col_ptr[m] == LAST);
         ld_next[m]  = ld[m] || (wr[m] && last_pos[m]);
      end
   end

   // Operand buffers; every entry is rewritten on each load so no reset is needed
   always_ff @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (wr[m]) begin
            mem[m][row_ptr[m]][col_ptr[m]] <= beat_acc[m] ? in_data : '0;
         end
      end
   end

   // Control FSM: load pointers/flags, compute step counter, output walk
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= ST_LOAD;
         ld        <= '0;
         pad_all   <= '0;
         row_ptr   <= '{default: '0};
         col_ptr   <= '{default: '0};
         k_ptr     <= '0;
         out_valid <= 1'b0;
         orow      <= '0;
         ocol      <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               for (int m = 0; m < 2; m++) begin
                  if (wr[m]) begin
                     if (col_ptr[m] == LAST) begin
                        col_ptr[m] <= '0;
                        row_ptr[m] <= (row_ptr[m] == LAST) ? '0 : row_ptr[m] + 1'b1;
                     end else begin
                        col_ptr[m] <= col_ptr[m] + 1'b1;
                     end
                     if (last_pos[m]) begin
                        pad_all[m] <= 1'b0;
                     end else if (beat_acc[m] && in_mat_done) begin
                        pad_all[m] <= 1'b1;
                     end
                  end
               end
               ld    <= ld_next;
               k_ptr <= '0;
               if (&ld_next) begin
                  state <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               if (k_ptr == LAST) begin
                  state     <= ST_OUTPUT;
                  out_valid <= 1'b1;
                  orow      <= '0;
                  ocol      <= '0;
               end else begin
                  k_ptr <= k_ptr + 1'b1;
               end
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  if ((orow == LAST) && (ocol == LAST)) begin
                     state     <= ST_LOAD;
                     out_valid <= 1'b0;
                     ld        <= '0;
                  end else if (ocol == LAST) begin
                     ocol <= '0;
                     orow <= orow + 1'b1;
                  end else begin
                     ocol <= ocol + 1'b1;
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   assign pe_clr = (state == ST_LOAD);
   assign pe_en  = (state == ST_COMPUTE);

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         fxpsm_mac_pe #(.N(N), .W(W), .FRAC(FRAC)) u_pe (
            .clk (clk),
            .clr (pe_clr),
            .en  (pe_en),
            .a   (mem[0][gi][k_ptr]),
            .b   (mem[1][k_ptr][gj]),
            .res (res[gi][gj])
         );
      end
   end

   assign out_data    = out_valid ? res[orow][ocol] : '0;
   assign out_new_row = out_valid && (ocol == '0);
   assign out_last    = out_valid && (orow == LAST) && (ocol == LAST);

endmodule

// File: tb/tb_fxpsm_matmul_array.sv
// tb/tb_fxpsm_matmul_array.sv - scoreboard bench for fxpsm_matmul_array at N=3, W=8, FRAC=3
module tb_fxpsm_matmul_array;

   logic       clk;
   logic       rstn;
   logic       in_valid;
   logic       in_ready;
   logic       in_mat;
   logic       in_new_row;
   logic       in_mat_done;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_new_row;
   logic       out_last;
   logic [7:0] out_data;

   typedef struct packed {
      logic [7:0] d;
      logic       nr;
      logic       lst;
   } exp_t;

   exp_t       exp_q[$];
   int         tests;
   int         fails;
   logic [7:0] ma [9];
   logic [7:0] mb [9];
   logic [7:0] mc [9];

   fxpsm_matmul_array #(.N(3), .W(8), .FRAC(3)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_mat      (in_mat),
      .in_new_row  (in_new_row),
      .in_mat_done (in_mat_done),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_new_row (out_new_row),
      .out_last    (out_last),
      .out_data    (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model_elem(input int i, input int j);
      int s, va, vb, m;
      s = 0;
      for (int k = 0; k < 3; k++) begin
         va = int'(ma[i*3+k][6:0]);
         if (ma[i*3+k][7]) va = -va;
         vb = int'(mb[k*3+j][6:0]);
         if (mb[k*3+j][7]) vb = -vb;
         s += va * vb;
      end
      m = (s < 0) ? -s : s;
      m = m / 8;
      if (m > 127) m = 127;
      if (m == 0) return 8'h00;
      return {(s < 0), 7'(m)};
   endfunction

   task automatic push_model();
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            exp_q.push_back('{d: model_elem(i, j), nr: (j == 0), lst: (i == 2 && j == 2)});
   endtask

   task automatic push_mc();
      for (int i = 0; i < 9; i++)
         exp_q.push_back('{d: mc[i], nr: (i % 3 == 0), lst: (i == 8)});
   endtask

   task automatic rand_ab();
      for (int i = 0; i < 9; i++) begin
         ma[i] = 8'($urandom_range(0, 255));
         mb[i] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic send_beat(input bit m, input bit nr, input bit dn, input logic [7:0] d,
                            output int stalls);
      bit ok;
      ok = 0;
      stalls = 0;
      in_valid = 1; in_mat = m; in_new_row = nr; in_mat_done = dn; in_data = d;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         else stalls++;
         @(posedge clk); #1;
      end
      in_valid = 0; in_mat_done = 0;
      if (!ok) begin
         tests++; fails++;
         $display("FAIL beat_timeout: in_ready stayed 0 got %0d stalls want accept", stalls);
      end
   endtask

   task automatic load_matrix(input bit m);
      int st;
      for (int i = 0; i < 9; i++) begin
         send_beat(m, (i % 3 == 0), (i == 8), m ? mb[i] : ma[i], st);
         tests++;
         if (st !== 0) begin
            fails++;
            $display("FAIL load_stall: mat %0d beat %0d got %0d stalls want 0", m, i, st);
         end
      end
   endtask

   task automatic wait_valid(input int want);
      int cyc;
      bit ok;
      cyc = 0; ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         if (out_valid) ok = 1;
         else begin
            tests++;
            if (in_ready !== 1'b0) begin
               fails++;
               $display("FAIL busy_in_ready: got %0b want 0", in_ready);
            end
            cyc++;
         end
         @(posedge clk); #1;
      end
      tests++;
      if (!ok || cyc !== want) begin
         fails++;
         $display("FAIL latency: got %0d cycles want %0d", cyc, want);
      end
   endtask

   task automatic drain(input bit toggle);
      int   cyc;
      bit   stalled;
      exp_t e;
      logic [9:0] held;
      cyc = 0; stalled = 0;
      while (exp_q.size() > 0 && cyc < 300) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         @(negedge clk);
         if (out_valid) begin
            if (stalled) begin
               tests++;
               if ({out_data, out_new_row, out_last} !== held) begin
                  fails++;
                  $display("FAIL hold: got %0h want %0h", {out_data, out_new_row, out_last}, held);
               end
            end
            if (out_ready) begin
               e = exp_q.pop_front();
               stalled = 0;
               tests++;
               if (out_data !== e.d || out_new_row !== e.nr || out_last !== e.lst) begin
                  fails++;
                  $display("FAIL out_elem: got d=%0h nr=%0b last=%0b want d=%0h nr=%0b last=%0b",
                           out_data, out_new_row, out_last, e.d, e.nr, e.lst);
               end
            end else begin
               stalled = 1;
               held = {out_data, out_new_row, out_last};
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 0;
      if (exp_q.size() > 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL after_last: got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_pair(input bit toggle);
      load_matrix(0);
      load_matrix(1);
      wait_valid(3);
      drain(toggle);
   endtask

   task automatic test_reset();
      rstn = 0; in_valid = 1; in_mat = 0; in_new_row = 1; in_mat_done = 0;
      in_data = 8'h55; out_ready = 1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
      tests++;
      if (out_new_row !== 1'b0 || out_last !== 1'b0) begin
         fails++; $display("FAIL rst_flags: got nr=%0b last=%0b want 0 0", out_new_row, out_last);
      end
      tests++;
      if (out_data !== 8'h00) begin fails++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
      @(posedge clk); #1;
      rstn = 1; in_valid = 0; out_ready = 0;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %0b want 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_identity();
      for (int i = 0; i < 9; i++) begin
         ma[i] = (i % 4 == 0) ? 8'h08 : 8'h00;
         mb[i] = 8'(i + 1);
         mc[i] = 8'(i + 1);
      end
      push_mc();
      run_pair(0);
   endtask

   task automatic test_sign();
      for (int i = 0; i < 9; i++) begin
         ma[i] = 8'h88; mb[i] = 8'h10; mc[i] = 8'hB0;
      end
      push_mc();
      run_pair(0);
      for (int i = 0; i < 9; i++) begin
         ma[i] = (i % 2 == 0) ? 8'h80 : 8'h00;
         mb[i] = 8'($urandom_range(0, 255));
         mc[i] = 8'h00;
      end
      push_mc();
      run_pair(0);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 9; i++) begin
         ma[i] = 8'h7F; mb[i] = 8'h7F; mc[i] = 8'h7F;
      end
      push_mc();
      run_pair(0);
      for (int i = 0; i < 9; i++) begin
         ma[i] = 8'hFF; mc[i] = 8'hFF;
      end
      push_mc();
      run_pair(0);
   endtask

   task automatic test_zero_pad(input bit b_first);
      int st;
      for (int i = 0; i < 9; i++) begin
         mb[i] = (i % 4 == 0) ? 8'h08 : 8'h00;
         mc[i] = 8'h00;
      end
      mc[0] = 8'h08;
      mc[4] = 8'h08;
      if (b_first) load_matrix(1);
      send_beat(0, 1, 0, 8'h08, st);
      tests++;
      if (st !== 0) begin fails++; $display("FAIL pad_beat0: got %0d stalls want 0", st); end
      send_beat(0, 1, 0, 8'h00, st);
      tests++;
      if (st !== 2) begin fails++; $display("FAIL row_pad_stalls: got %0d want 2", st); end
      send_beat(0, 0, 1, 8'h08, st);
      tests++;
      if (st !== 0) begin fails++; $display("FAIL pad_done_beat: got %0d stalls want 0", st); end
      if (!b_first) load_matrix(1);
      push_mc();
      in_mat = 0;
      wait_valid(b_first ? 7 : 3);
      drain(0);
   endtask

   task automatic test_back_to_back();
      rand_ab();
      push_model();
      run_pair(1);
      rand_ab();
      push_model();
      run_pair(0);
   endtask

   task automatic test_reset_abort();
      int hi;
      rand_ab();
      load_matrix(0);
      load_matrix(1);
      @(posedge clk); #1;
      rstn = 0;
      @(posedge clk); #1;
      rstn = 1;
      hi = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) hi++;
         @(posedge clk); #1;
      end
      tests++;
      if (hi !== 0) begin fails++; $display("FAIL rst_compute_valid: got %0d valid cycles want 0", hi); end
      rand_ab();
      push_model();
      run_pair(0);
      rand_ab();
      load_matrix(0);
      load_matrix(1);
      wait_valid(3);
      out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      out_ready = 0;
      rstn = 0;
      @(posedge clk); #1;
      rstn = 1;
      hi = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) hi++;
         @(posedge clk); #1;
      end
      tests++;
      if (hi !== 0) begin fails++; $display("FAIL rst_output_valid: got %0d valid cycles want 0", hi); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_identity();
      test_sign();
      test_saturation();
      test_zero_pad(1);
      test_zero_pad(0);
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
